// File: rtl/alu_pkg.sv
// Shared opcode encoding, sequencer states and helpers for the execute-stage ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b10000;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b10101;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    // 01xxx is the whole multiply/divide block
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle multiply / restoring-divide engine. Works on magnitudes and
// applies the result sign in FIX; op is opcode[2:0] of the MUL*/DIV*/REM* block.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         idle,
    output logic         done,
    output logic [W-1:0] res
);

    state_t         state, nxt;
    logic [SHW-1:0] cnt;
    logic [2*W-1:0] acc, prod;
    logic [W-1:0]   mag_b, quo, rmd;
    logic [2:0]     op_q;
    logic           neg;

    logic           sa, sb;
    logic [W-1:0]   ma, mb, rem_nxt;
    logic [W:0]     sum, trial, diff;

    // Operand signedness: MULH both, MULHSU A only, DIV/REM both
    always_comb begin
        sa = a[W-1] && (op[2] ? !op[0] : (op[1] ^ op[0]));
        sb = b[W-1] && (op[2] ? !op[0] : (op[1:0] == 2'b01));
        ma = sa ? -a : a;
        mb = sb ? -b : b;
    end

    // acc = {high, low}: product while multiplying, {remainder, quotient} while dividing
    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : '0);
        trial   = {acc[2*W-1:W], acc[W-1]};
        diff    = trial - {1'b0, mag_b};
        rem_nxt = diff[W] ? trial[W-1:0] : diff[W-1:0];
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = op[2] ? DIV : MUL;
            MUL,
            DIV:     if (cnt == SHW'(W-1)) nxt = FIX;
            FIX:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mag_b <= '0;
            op_q  <= '0;
            neg   <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (start) begin
                    cnt   <= '0;
                    acc   <= {{W{1'b0}}, ma};
                    mag_b <= mb;
                    op_q  <= op;
                    // remainder takes the dividend's sign, everything else the xor
                    neg   <= (op[2] && op[1]) ? sa : (sa ^ sb);
                end
                MUL: begin
                    acc <= {sum, acc[W-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= {rem_nxt, acc[W-2:0], !diff[W]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[W-1:0] : acc[W-1:0];
        rmd  = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (op_q[2])
            res = op_q[1] ? rmd : quo;
        else
            res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end

    assign idle = state == IDLE;
    assign done = state == FIX;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops and division special cases
// resolve at accept, MUL*/DIV*/REM* go through the iterative engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [4:0]   opcode,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         zero
);

    logic         accept, direct, special, div_op, by0, ovf, start;
    logic         eng_idle, eng_done;
    logic [W-1:0] eng_res, alu_y, spec_y, load_y;

    assign in_ready = eng_idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // RISC-V divide corner cases never enter the engine
    assign div_op  = opcode[4:2] == 3'b011;
    assign by0     = B == '0;
    assign ovf     = !opcode[0] && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
    assign special = div_op && (by0 || ovf);
    assign spec_y  = by0 ? (opcode[1] ? A : '1) : (opcode[1] ? '0 : A);
    assign direct  = !is_muldiv(opcode) || special;
    assign start   = accept && !direct && !flush;

    always_comb begin
        alu_y = A + B;
        case (opcode)
            OP_SUB:  alu_y = A - B;
            OP_AND:  alu_y = A & B;
            OP_OR:   alu_y = A | B;
            OP_XOR:  alu_y = A ^ B;
            OP_SLL:  alu_y = A << B[SHW-1:0];
            OP_SRL:  alu_y = A >> B[SHW-1:0];
            OP_SRA:  alu_y = $signed(A) >>> B[SHW-1:0];
            OP_SLT:  alu_y = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: alu_y = {{(W-1){1'b0}}, A < B};
            default: ;
        endcase
    end

    assign load_y = eng_done ? eng_res : (special ? spec_y : alu_y);

    alu_muldiv_iter #(.W(W)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .kill  (flush),
        .start (start),
        .op    (opcode[2:0]),
        .a     (A),
        .b     (B),
        .idle  (eng_idle),
        .done  (eng_done),
        .res   (eng_res)
    );

    // Engine completion cannot coincide with an accept since in_ready is low in FIX
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            Y         <= '0;
            zero      <= 1'b1;
        end else if (eng_done || (accept && direct)) begin
            out_valid <= 1'b1;
            Y         <= load_y;
            zero      <= load_y == '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=32): vector table plus handshake, flush and reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, zero;
    logic [31:0] A = '0, B = '0, Y;
    logic [4:0]  opcode = '0;

    int          n_vec = 0, n_err = 0;
    logic [32:0] sbq[$];
    logic [32:0] mon_e;
    bit          rnd_done = 1'b0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    alu_seq #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every consumed result is checked against the oldest expectation
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL result: unexpected Y=%h zero=%b", Y, zero);
            end else begin
                mon_e = sbq.pop_front();
                if ({zero, Y} !== mon_e) begin
                    n_err++;
                    $display("FAIL result: got Y=%h zero=%b want Y=%h zero=%b",
                             Y, zero, mon_e[31:0], mon_e[32]);
                end
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] ey);
        int t = 0;
        in_valid = 1'b1; opcode = op; A = a; B = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept timeout: op=%b in_ready=%b want 1", op, in_ready);
        end else if (push) begin
            sbq.push_back({ey == 32'd0, ey});
        end
        @(posedge clk); #1;
        // scramble inputs so a result depending on post-accept operands shows up
        in_valid = 1'b0; A = $urandom; B = $urandom; opcode = 5'($urandom);
    endtask

    // Called right after the accept edge; returns just after out_valid rises
    task automatic wait_out(input string name, input int lat, input bit chk_rdy);
        int n = 1;
        bit rdy_low = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, lat);
        if (chk_rdy) check({name, " in_ready low"}, 32'(rdy_low), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv.push_back('{"add",        OP_ADD,    32'd7,          32'd5,          32'd12,         1});
        tv.push_back('{"sub",        OP_SUB,    32'd5,          32'd7,          32'hFFFFFFFE,   1});
        tv.push_back('{"add wrap",   OP_ADD,    32'hFFFFFFFF,   32'd1,          32'd0,          1});
        tv.push_back('{"and",        OP_AND,    32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1});
        tv.push_back('{"or",         OP_OR,     32'hF0F0F0F0,   32'h0FF00FF0,   32'hFFF0FFF0,   1});
        tv.push_back('{"xor",        OP_XOR,    32'hA5A5A5A5,   32'hA5A5A5A5,   32'd0,          1});
        tv.push_back('{"sll",        OP_SLL,    32'd1,          32'd31,         32'h80000000,   1});
        tv.push_back('{"srl amt5",   OP_SRL,    32'h80000000,   32'd35,         32'h10000000,   1});
        tv.push_back('{"sra",        OP_SRA,    32'h80000000,   32'd4,          32'hF8000000,   1});
        tv.push_back('{"slt",        OP_SLT,    32'hFFFFFFFF,   32'd1,          32'd1,          1});
        tv.push_back('{"sltu",       OP_SLTU,   32'hFFFFFFFF,   32'd1,          32'd0,          1});
        tv.push_back('{"mul",        OP_MUL,    32'hFFFFFFFF,   32'd3,          32'hFFFFFFFD,   34});
        tv.push_back('{"mulh",       OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          34});
        tv.push_back('{"mulhu",      OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   34});
        tv.push_back('{"mulhsu",     OP_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   34});
        tv.push_back('{"div ovf",    OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
        tv.push_back('{"rem by0",    OP_REM,    32'd13,         32'd0,          32'd13,         1});
        tv.push_back('{"divu by0",   OP_DIVU,   32'd5,          32'd0,          32'hFFFFFFFF,   1});
        tv.push_back('{"rem ovf",    OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
        tv.push_back('{"div -7/2",   OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34});
        tv.push_back('{"rem -7/2",   OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34});
        tv.push_back('{"div 7/-2",   OP_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34});
        tv.push_back('{"rem 7/-2",   OP_REM,    32'd7,          32'hFFFFFFFE,   32'd1,          34});
        tv.push_back('{"divu",       OP_DIVU,   32'd100,        32'd7,          32'd14,         34});
        tv.push_back('{"remu",       OP_REMU,   32'd100,        32'd7,          32'd2,          34});
        tv.push_back('{"default op", 5'b11111,  32'd3,          32'd4,          32'd7,          1});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset Y", Y, 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        foreach (tv[i]) begin
            send(tv[i].op, tv[i].a, tv[i].b, 1'b1, tv[i].y);
            wait_out(tv[i].name, tv[i].lat, tv[i].lat > 1);
        end

        // Random single-cycle stream under random backpressure
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] ra, rb;
                    ra = $urandom; rb = $urandom;
                    if (i % 2 == 0) send(OP_ADD, ra, rb, 1'b1, ra + rb);
                    else            send(OP_XOR, ra, rb, 1'b1, ra ^ rb);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Held result under backpressure
        out_ready = 1'b0;
        send(OP_SRA, 32'h80000000, 32'd4, 1'b1, 32'hF8000000);
        wait_out("sra held", 1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("held Y", Y, 32'hF8000000);
            check("held in_ready", 32'(in_ready), 32'd0);
            check("held out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush 10 cycles into a DIVU
        send(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check("busy in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        send(OP_DIVU, 32'd1000, 32'd9, 1'b1, 32'd111);
        wait_out("divu after flush", 34, 1'b1);

        // Reset in the middle of a multiply
        send(OP_MUL, 32'd3, 32'd5, 1'b0, 32'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midop reset Y", Y, 32'd0);
        check("midop reset zero", 32'(zero), 32'd1);
        check("midop reset out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        send(5'b11111, 32'd3, 32'd4, 1'b1, 32'd7);
        wait_out("default after reset", 1, 1'b0);
        send(OP_MUL, 32'd6, 32'd7, 1'b1, 32'd42);
        wait_out("mul after reset", 34, 1'b1);

        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        check("scoreboard drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
